// File: rtl/ultrasonic_range_sequencer_if.sv
// Sensor-side and result-side signals of the ultrasonic range sequencer.
// The master modport is the sequencer; the slave modport is the board/drive side.
interface ultrasonic_range_sequencer_if #(
  parameter int DIST_W = 9
);
  logic              enable;
  logic              echo;
  logic              trig;
  logic [DIST_W-1:0] dist_cm;
  logic              dist_valid;
  logic              timeout;
  logic              near;
  logic              busy;

  modport master (
    input  enable, echo,
    output trig, dist_cm, dist_valid, timeout, near, busy
  );

  modport slave (
    output enable, echo,
    input  trig, dist_cm, dist_valid, timeout, near, busy
  );
endinterface

// File: rtl/ultrasonic_range_sequencer.sv
// HC-SR04 style sequencer: trigger pulse, echo width in cm, fixed period,
// distance publish with timeout qualifier and a hysteretic near flag.
module ultrasonic_range_sequencer #(
  parameter int TRIG_CYCLES    = 1000,
  parameter int TICK_CYCLES    = 5800,
  parameter int MAX_CM         = 400,
  parameter int RISE_TO_CYCLES = 200000,
  parameter int PERIOD_CYCLES  = 6000000,
  parameter int NEAR_CM        = 20,
  parameter int HYST_CM        = 5,
  parameter int DIST_W         = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  ultrasonic_range_sequencer_if.master  bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] TRIG      = 3'd1;
  localparam logic [2:0] WAIT_RISE = 3'd2;
  localparam logic [2:0] MEASURE   = 3'd3;
  localparam logic [2:0] HOLDOFF   = 3'd4;

  localparam int PH_MAX_A = (TRIG_CYCLES > TICK_CYCLES) ? TRIG_CYCLES : TICK_CYCLES;
  localparam int PH_MAX   = (PH_MAX_A > RISE_TO_CYCLES) ? PH_MAX_A : RISE_TO_CYCLES;
  localparam int PH_W     = $clog2(PH_MAX + 1);
  localparam int PER_W    = $clog2(PERIOD_CYCLES + 1);

  localparam logic [PH_W-1:0]   TRIG_LAST = PH_W'(TRIG_CYCLES - 1);
  localparam logic [PH_W-1:0]   TICK_LAST = PH_W'(TICK_CYCLES - 1);
  localparam logic [PH_W-1:0]   RISE_LAST = PH_W'(RISE_TO_CYCLES - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [DIST_W-1:0] MAX_LIM   = DIST_W'(MAX_CM);
  localparam logic [DIST_W:0]   SET_LIM   = (DIST_W+1)'(NEAR_CM);
  localparam logic [DIST_W:0]   CLR_LIM   = (DIST_W+1)'(NEAR_CM + HYST_CM);

  logic [2:0]        state;
  logic              echo_s1, echo_s2, echo_d;
  logic [PH_W-1:0]   cnt;
  logic [PER_W-1:0]  period_cnt;
  logic [DIST_W-1:0] cm;
  logic              trig_r, dist_valid_r, timeout_r, near_r;
  logic [DIST_W-1:0] dist_cm_r;

  logic              rise, fall, tick, period_done;
  logic [DIST_W-1:0] cm_inc;
  logic              pub_en, pub_tmo;
  logic [DIST_W-1:0] pub_dist;

  assign rise        = echo_s2 & ~echo_d;
  assign fall        = ~echo_s2 & echo_d;
  assign tick        = (cnt == TICK_LAST);
  assign cm_inc      = cm + DIST_W'(1);
  assign period_done = (period_cnt >= PER_LAST);

  // The fall cycle still runs the divider, so MEASURE spans exactly W cycles.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    pub_en   = 1'b0;
    pub_tmo  = 1'b1;
    pub_dist = MAX_LIM;
    case (state)
      WAIT_RISE: if (!rise && cnt == RISE_LAST) pub_en = 1'b1;
      MEASURE: begin
        if (tick && cm_inc == MAX_LIM) begin
          pub_en = 1'b1;
        end else if (fall) begin
          pub_en   = 1'b1;
          pub_tmo  = 1'b0;
          pub_dist = tick ? cm_inc : cm;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_s1 <= 1'b0;
      echo_s2 <= 1'b0;
      echo_d  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      echo_s1 <= bus.echo;
      echo_s2 <= echo_s1;
      echo_d  <= echo_s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      trig_r       <= 1'b0;
      cnt          <= '0;
      cm           <= '0;
      period_cnt   <= '0;
      dist_cm_r    <= '0;
      dist_valid_r <= 1'b0;
      timeout_r    <= 1'b0;
      near_r       <= 1'b0;
    end else begin
      dist_valid_r <= 1'b0;
      if (period_cnt != '1) period_cnt <= period_cnt + PER_W'(1);

      if (pub_en) begin
        dist_cm_r    <= pub_dist;
        timeout_r    <= pub_tmo;
        dist_valid_r <= 1'b1;
        if (pub_tmo)                           near_r <= 1'b0;
        else if ({1'b0, pub_dist} <= SET_LIM)  near_r <= 1'b1;
        else if ({1'b0, pub_dist} >= CLR_LIM)  near_r <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.enable) begin
            state      <= TRIG;
            trig_r     <= 1'b1;
            cnt        <= '0;
            period_cnt <= '0;
          end
        end
        TRIG: begin
          if (cnt == TRIG_LAST) begin
            state  <= WAIT_RISE;
            trig_r <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= cnt + PH_W'(1);
          end
        end
        WAIT_RISE: begin
          if (rise) begin
            state <= MEASURE;
            cnt   <= '0;
            cm    <= '0;
          end else if (pub_en) begin
            state <= HOLDOFF;
          end else begin
            cnt <= cnt + PH_W'(1);
          end
        end
        MEASURE: begin
          if (pub_en) state <= HOLDOFF;
          if (tick) begin
            cnt <= '0;
            cm  <= cm_inc;
          end else begin
            cnt <= cnt + PH_W'(1);
          end
        end
        HOLDOFF: begin
          // A still-high echo (e.g. after saturation) holds off the next trigger.
          if (period_done && !echo_s2) begin
            if (bus.enable) begin
              state      <= TRIG;
              trig_r     <= 1'b1;
              cnt        <= '0;
              period_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.trig       = trig_r;
  assign bus.dist_cm    = dist_cm_r;
  assign bus.dist_valid = dist_valid_r;
  assign bus.timeout    = timeout_r;
  assign bus.near       = near_r;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_ultrasonic_range_sequencer.sv
// Randomized bench for ultrasonic_range_sequencer against a timing/arithmetic
// reference model of trigger times, publish times, distances and the near flag.
module tb_ultrasonic_range_sequencer;

  localparam int TRIG_CYCLES    = 4;
  localparam int TICK_CYCLES    = 10;
  localparam int MAX_CM         = 20;
  localparam int RISE_TO_CYCLES = 50;
  localparam int PERIOD_CYCLES  = 400;
  localparam int NEAR_CM        = 5;
  localparam int HYST_CM        = 2;
  localparam int DIST_W         = 9;
  // Input change to registered output, through the 2-FF synchroniser and edge detector.
  localparam int LAT            = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ultrasonic_range_sequencer_if #(.DIST_W(DIST_W)) bus ();

  ultrasonic_range_sequencer #(
    .TRIG_CYCLES(TRIG_CYCLES), .TICK_CYCLES(TICK_CYCLES), .MAX_CM(MAX_CM),
    .RISE_TO_CYCLES(RISE_TO_CYCLES), .PERIOD_CYCLES(PERIOD_CYCLES),
    .NEAR_CM(NEAR_CM), .HYST_CM(HYST_CM), .DIST_W(DIST_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int   c;
    int   d;
    logic t;
    logic n;
  } pub_t;

  pub_t pubs[$];
  int   trig_rises[$];
  logic trig_q = 1'b0;

  // Reference state: expected next trigger cycle, last published distance, near flag.
  int   exp_next;
  int   last_d;
  logic near_m;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.dist_valid) pubs.push_back('{cyc, int'(bus.dist_cm), bus.timeout, bus.near});
    if (bus.trig && !trig_q) trig_rises.push_back(cyc);
    trig_q <= bus.trig;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_trig(output int t);
    for (int i = 0; i < 2000 && trig_rises.size() == 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (trig_rises.size() == 0) begin
      check("trig_missing", 0, 1);
      t = cyc;
    end else begin
      t = trig_rises.pop_front();
    end
  endtask

  // One measurement: echo of w cycles starting d cycles after trig falls (w=0: no echo).
  task automatic run_period(input int w, input int d, input bit drop);
    int   t, k, exp_c, exp_d;
    logic exp_t;
    pub_t p;
    check("extra_pub", pubs.size(), 0);
    wait_trig(t);
    check("trig_start", t, exp_next);
    check("dist_hold", bus.dist_cm, last_d);
    check("busy_run", bus.busy, 1);
    wait_cyc(t + TRIG_CYCLES - 1);
    check("trig_high", bus.trig, 1);
    wait_cyc(t + TRIG_CYCLES);
    check("trig_fall", bus.trig, 0);

    k = t + TRIG_CYCLES + d;
    if (w == 0) begin
      exp_c = t + TRIG_CYCLES + RISE_TO_CYCLES;
      exp_d = MAX_CM;
      exp_t = 1'b1;
      exp_next = t + PERIOD_CYCLES;
    end else begin
      if (w >= MAX_CM * TICK_CYCLES) begin
        exp_c = k + MAX_CM * TICK_CYCLES + LAT;
        exp_d = MAX_CM;
        exp_t = 1'b1;
      end else begin
        exp_c = k + w + LAT;
        exp_d = w / TICK_CYCLES;
        exp_t = 1'b0;
      end
      exp_next = (t + PERIOD_CYCLES > k + w + LAT) ? t + PERIOD_CYCLES : k + w + LAT;
    end
    if (exp_t)                           near_m = 1'b0;
    else if (exp_d <= NEAR_CM)           near_m = 1'b1;
    else if (exp_d >= NEAR_CM + HYST_CM) near_m = 1'b0;

    if (w > 0) begin
      wait_cyc(k);
      bus.echo = 1'b1;
      if (drop) begin
        wait_cyc(k + 20);
        bus.enable = 1'b0;
      end
      wait_cyc(k + w);
      bus.echo = 1'b0;
    end

    for (int i = 0; i < 1000 && pubs.size() == 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (pubs.size() == 0) begin
      check("pub_missing", 0, 1);
    end else begin
      p = pubs.pop_front();
      check("pub_cycle", p.c, exp_c);
      check("pub_dist", p.d, exp_d);
      check("pub_timeout", p.t, exp_t);
      check("pub_near", p.n, near_m);
    end
    last_d = exp_d;

    if (drop) begin
      wait_cyc(t + PERIOD_CYCLES - 1);
      check("busy_holdoff", bus.busy, 1);
      wait_cyc(t + PERIOD_CYCLES);
      check("busy_idle", bus.busy, 0);
      wait_cyc(t + PERIOD_CYCLES + 300);
      check("no_trig_idle", trig_rises.size(), 0);
      check("extra_pub_idle", pubs.size(), 0);
    end
  endtask

  initial begin
    int t, w, d, r;
    bus.enable = 1'b1;
    bus.echo   = 1'b0;
    last_d     = 0;
    near_m     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_trig", bus.trig, 0);
    check("rst_dist", bus.dist_cm, 0);
    check("rst_valid", bus.dist_valid, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_near", bus.near, 0);
    check("rst_busy", bus.busy, 0);
    rst      = 1'b0;
    exp_next = cyc + 1;

    // Distances and hysteresis, then saturation, no-echo and boundary widths.
    run_period(73, 10, 1'b0);
    run_period(40, 5, 1'b0);
    run_period(60, 0, 1'b0);
    run_period(70, 20, 1'b0);
    run_period(40, 12, 1'b0);
    run_period(300, 7, 1'b0);
    run_period(30, 3, 1'b0);
    run_period(0, 0, 1'b0);
    run_period(450, 3, 1'b0);
    run_period(199, 1, 1'b0);
    run_period(200, 2, 1'b0);
    run_period(55, 47, 1'b0);
    run_period(1, 9, 1'b0);

    for (int i = 0; i < 5; i++) run_period(30, $urandom_range(0, 47), 1'b0);

    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(0, 9);
      d = $urandom_range(0, 47);
      if (r == 0)      w = 0;
      else if (r == 1) w = $urandom_range(195, 260);
      else             w = $urandom_range(1, 199);
      run_period(w, d, 1'b0);
    end

    run_period(60, 4, 1'b1);

    // Reset in the middle of a measurement.
    bus.enable = 1'b1;
    exp_next   = cyc + 1;
    wait_trig(t);
    check("restart_trig", t, exp_next);
    wait_cyc(t + TRIG_CYCLES + 5);
    bus.echo = 1'b1;
    wait_cyc(t + TRIG_CYCLES + 35);
    rst = 1'b1;
    #1;
    check("midrst_trig", bus.trig, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_dist", bus.dist_cm, 0);
    check("midrst_near", bus.near, 0);
    check("midrst_timeout", bus.timeout, 0);
    bus.enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.echo = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    check("midrst_no_pub", pubs.size(), 0);
    check("midrst_no_trig", trig_rises.size(), 0);
    check("midrst_valid", bus.dist_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
